if_stage: RTL and testbench

- Instruction fetch stage directly upstream of the instruction memory.
- Holds the PC and drives the word address into instruction memory; instruction memory answers combinationally in the same cycle.
- Captures the returned instruction word and PC+4 into the IF/ID pipeline register for decode.
- Computes the next PC from sequential, branch, jump and jump-register requests issued by decode.

---
 rtl/if_stage_pkg.sv | 21 ++
 rtl/if_stage_npc_calc.sv | 53 +++++
 rtl/if_stage.sv | 73 +++++++
 tb/tb_if_stage.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared encodings and constants for the instruction fetch stage
package if_stage_pkg;

    typedef enum logic [1:0] {
        NPC_PC4 = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_sel_e;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
    localparam logic [31:0] PC_MAX_DEF    = 32'h0000_FFFC;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    // Opcode field values of the control-flow instructions that drive npc_sel
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;

endpackage

// File: rtl/if_stage_npc_calc.sv
// rtl/if_stage_npc_calc.sv - combinational next-PC selection for the fetch stage
module if_stage_npc_calc
    import if_stage_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] ifid_pc4,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc,
    output logic        redirect,
    output logic        jr_misaligned
);

    logic [31:0] pc4;
    logic [31:0] br_target;

    assign pc4 = pc + 32'd4;
    // Branches and jumps are relative to the instruction in ID, not the fetch PC
    assign br_target = ifid_pc4 + {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        next_pc       = pc4;
        redirect      = 1'b0;
        jr_misaligned = 1'b0;
        case (npc_sel_e'(npc_sel))
            NPC_PC4: begin
                next_pc = pc4;
            end
            NPC_BR: begin
                if (br_taken) begin
                    next_pc  = br_target;
                    redirect = 1'b1;
                end
            end
            NPC_J: begin
                next_pc  = {ifid_pc4[31:28], imm26, 2'b00};
                redirect = 1'b1;
            end
            NPC_JR: begin
                next_pc       = {jr_target[31:2], 2'b00};
                redirect      = 1'b1;
                jr_misaligned = (jr_target[1:0] != 2'b00);
            end
            default: begin
                next_pc = pc4;
            end
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - PC register, IF/ID pipeline register, stall/flush and fetch address checking
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] PC_MAX    = PC_MAX_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] jr_target,
    output logic [13:0] im_addr,
    input  logic [31:0] im_dout,
    output logic [31:0] pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        addr_err
);

    logic [31:0] next_pc;
    logic        redirect;
    logic        jr_misaligned;
    logic        range_err;

    assign im_addr = pc[15:2];

    if_stage_npc_calc u_npc_calc (
        .pc            (pc),
        .ifid_pc4      (ifid_pc4),
        .npc_sel       (npc_sel),
        .br_taken      (br_taken),
        .imm16         (imm16),
        .imm26         (imm26),
        .jr_target     (jr_target),
        .next_pc       (next_pc),
        .redirect      (redirect),
        .jr_misaligned (jr_misaligned)
    );

    // The PC still loads an out-of-range value; only the sticky flag records it
    assign range_err = (next_pc < RESET_PC) || (next_pc > PC_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            ifid_instr <= NOP_INSTR;
            ifid_pc4   <= 32'd0;
            ifid_valid <= 1'b0;
            addr_err   <= 1'b0;
        end else if (!stall) begin
            pc <= next_pc;
            if (redirect) begin
                ifid_instr <= NOP_INSTR;
                ifid_pc4   <= 32'd0;
                ifid_valid <= 1'b0;
            end else begin
                ifid_instr <= im_dout;
                ifid_pc4   <= next_pc;
                ifid_valid <= 1'b1;
            end
            if (range_err || jr_misaligned) begin
                addr_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [1:0]  npc_sel;
    logic        br_taken;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] jr_target;
    logic [13:0] im_addr;
    logic [31:0] im_dout;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        addr_err;

    int tests;
    int fails;

    if_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .npc_sel    (npc_sel),
        .br_taken   (br_taken),
        .imm16      (imm16),
        .imm26      (imm26),
        .jr_target  (jr_target),
        .im_addr    (im_addr),
        .im_dout    (im_dout),
        .pc         (pc),
        .ifid_instr (ifid_instr),
        .ifid_pc4   (ifid_pc4),
        .ifid_valid (ifid_valid),
        .addr_err   (addr_err)
    );

    // Instruction memory: word at RESET_PC holds 0, next word 1, and so on
    assign im_dout = {18'd0, im_addr} - 32'h0000_0C00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; npc_sel = 2'd0; br_taken = 1'b0;
        imm16 = 16'h0; imm26 = 26'h0; jr_target = 32'h0;
        @(negedge clk);
        @(negedge clk);
        tests++; if (pc !== 32'h3000) begin fails++; $display("FAIL reset_pc: got %h want %h", pc, 32'h3000); end
        tests++; if (im_addr !== 14'hC00) begin fails++; $display("FAIL reset_im_addr: got %h want %h", im_addr, 14'hC00); end
        tests++; if ({ifid_instr, ifid_pc4, ifid_valid, addr_err} !== 66'h0) begin fails++;
            $display("FAIL reset_ifid: got instr=%h pc4=%h v=%b err=%b want 0", ifid_instr, ifid_pc4, ifid_valid, addr_err); end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        npc_sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_pc = 32'h3004 + 32'(4 * i);
            tests++; if (pc !== exp_pc) begin fails++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc, exp_pc); end
            tests++; if (ifid_instr !== 32'(i)) begin fails++; $display("FAIL seq_instr[%0d]: got %h want %h", i, ifid_instr, 32'(i)); end
            tests++; if (ifid_pc4 !== exp_pc) begin fails++; $display("FAIL seq_pc4[%0d]: got %h want %h", i, ifid_pc4, exp_pc); end
            tests++; if (ifid_valid !== 1'b1) begin fails++; $display("FAIL seq_valid[%0d]: got %b want 1", i, ifid_valid); end
        end
    endtask

    task automatic test_branch();
        npc_sel = 2'd1; br_taken = 1'b1; imm16 = 16'hFFFC;
        tick();
        tests++; if (pc !== 32'h3000) begin fails++; $display("FAIL br_taken_pc: got %h want %h", pc, 32'h3000); end
        tests++; if ({ifid_instr, ifid_pc4, ifid_valid} !== 65'h0) begin fails++;
            $display("FAIL br_taken_flush: got instr=%h pc4=%h v=%b want 0", ifid_instr, ifid_pc4, ifid_valid); end
        br_taken = 1'b0;
        tick();
        tests++; if (pc !== 32'h3004) begin fails++; $display("FAIL br_nt_pc: got %h want %h", pc, 32'h3004); end
        tests++; if ({ifid_instr, ifid_pc4, ifid_valid} !== {32'h0, 32'h3004, 1'b1}) begin fails++;
            $display("FAIL br_nt_ifid: got instr=%h pc4=%h v=%b want 0/3004/1", ifid_instr, ifid_pc4, ifid_valid); end
    endtask

    task automatic test_jump();
        npc_sel = 2'd0;
        tick();
        tests++; if (ifid_pc4 !== 32'h3008) begin fails++; $display("FAIL j_setup_pc4: got %h want %h", ifid_pc4, 32'h3008); end
        npc_sel = 2'd2; imm26 = 26'h0000C10;
        tick();
        tests++; if (pc !== 32'h3040) begin fails++; $display("FAIL j_pc: got %h want %h", pc, 32'h3040); end
        tests++; if (ifid_valid !== 1'b0) begin fails++; $display("FAIL j_flush_valid: got %b want 0", ifid_valid); end
        tests++; if (addr_err !== 1'b0) begin fails++; $display("FAIL j_addr_err: got %b want 0", addr_err); end
    endtask

    task automatic test_stall();
        npc_sel = 2'd0;
        tick();
        npc_sel = 2'd2; imm26 = 26'h0000C20; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if ({pc, ifid_instr, ifid_pc4, ifid_valid} !== {32'h3044, 32'h10, 32'h3044, 1'b1}) begin fails++;
                $display("FAIL stall_hold[%0d]: got pc=%h instr=%h pc4=%h v=%b want 3044/10/3044/1", i, pc, ifid_instr, ifid_pc4, ifid_valid); end
        end
        stall = 1'b0;
        tick();
        tests++; if (pc !== 32'h3080) begin fails++; $display("FAIL stall_release_pc: got %h want %h", pc, 32'h3080); end
        tests++; if (ifid_valid !== 1'b0) begin fails++; $display("FAIL stall_release_valid: got %b want 0", ifid_valid); end
    endtask

    task automatic test_jr_misaligned();
        npc_sel = 2'd3; jr_target = 32'h3022;
        tick();
        tests++; if (pc !== 32'h3020) begin fails++; $display("FAIL jr_pc: got %h want %h", pc, 32'h3020); end
        tests++; if (addr_err !== 1'b1) begin fails++; $display("FAIL jr_misalign_err: got %b want 1", addr_err); end
        npc_sel = 2'd0;
        tick();
        tick();
        tests++; if (addr_err !== 1'b1) begin fails++; $display("FAIL jr_err_sticky: got %b want 1", addr_err); end
        tests++; if (pc !== 32'h3028) begin fails++; $display("FAIL jr_after_pc: got %h want %h", pc, 32'h3028); end
    endtask

    task automatic test_async_reset();
        npc_sel = 2'd3; jr_target = 32'h3100;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        tests++; if ({pc, ifid_instr, ifid_pc4, ifid_valid, addr_err} !== {32'h3000, 32'h0, 32'h0, 2'b00}) begin fails++;
            $display("FAIL async_rst: got pc=%h instr=%h pc4=%h v=%b err=%b want 3000/0/0/0/0", pc, ifid_instr, ifid_pc4, ifid_valid, addr_err); end
        @(negedge clk);
        rst = 1'b0; npc_sel = 2'd0;
        tick();
        tests++; if ({pc, ifid_instr, ifid_pc4, ifid_valid} !== {32'h3004, 32'h0, 32'h3004, 1'b1}) begin fails++;
            $display("FAIL async_resume: got pc=%h instr=%h pc4=%h v=%b want 3004/0/3004/1", pc, ifid_instr, ifid_pc4, ifid_valid); end
    endtask

    task automatic test_pc_max();
        npc_sel = 2'd3; jr_target = 32'h0000_FFFC;
        tick();
        tests++; if ({pc, addr_err} !== {32'hFFFC, 1'b0}) begin fails++; $display("FAIL pcmax_jr: got pc=%h err=%b want FFFC/0", pc, addr_err); end
        npc_sel = 2'd0;
        tick();
        tests++; if (pc !== 32'h0001_0000) begin fails++; $display("FAIL pcmax_wrap_pc: got %h want %h", pc, 32'h10000); end
        tests++; if (addr_err !== 1'b1) begin fails++; $display("FAIL pcmax_err: got %b want 1", addr_err); end
        tests++; if ({ifid_instr, ifid_pc4} !== {32'h33FF, 32'h0001_0000}) begin fails++;
            $display("FAIL pcmax_ifid: got instr=%h pc4=%h want 33FF/10000", ifid_instr, ifid_pc4); end
        tick();
        tests++; if (addr_err !== 1'b1) begin fails++; $display("FAIL pcmax_sticky: got %b want 1", addr_err); end
    endtask

    task automatic test_jr_low();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if (addr_err !== 1'b0) begin fails++; $display("FAIL err_clear_by_rst: got %b want 0", addr_err); end
        npc_sel = 2'd3; jr_target = 32'h2FFC;
        tick();
        tests++; if ({pc, addr_err} !== {32'h2FFC, 1'b1}) begin fails++; $display("FAIL jr_low: got pc=%h err=%b want 2FFC/1", pc, addr_err); end
        npc_sel = 2'd0;
        tick();
        tests++; if ({pc, addr_err} !== {32'h3000, 1'b1}) begin fails++; $display("FAIL jr_low_sticky: got pc=%h err=%b want 3000/1", pc, addr_err); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall();
        test_jr_misaligned();
        test_async_reset();
        test_pc_max();
        test_jr_low();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
